// File: rtl/ceres_param.sv
// Shared lowX port types and parameters.
// Used by the L1 caches and the L2 port responders.
package ceres_param;

  localparam int BLK_SIZE = 128;
  localparam int ID_W     = 4;

  typedef enum logic [1:0] {
    NO_SIZE,
    BYTE,
    HALF,
    WORD
  } rw_size_e;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [31:0]         addr;
    logic                uncached;
    logic [ID_W-1:0]     id;
    logic                rw;
    rw_size_e            rw_size;
    logic [BLK_SIZE-1:0] data;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
    logic [ID_W-1:0]     id;
  } lowX_res_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } l2_resp_state_e;

endpackage

// File: rtl/l2_wstrb_gen.sv
// Byte-strobe generator for one lowX write.
// Partial accesses are aligned down to their natural size.
module l2_wstrb_gen #(
  parameter int BLK_SIZE = 128
) (
  input  logic                         rw,
  input  ceres_param::rw_size_e        rw_size,
  input  logic [$clog2(BLK_SIZE/8)-1:0] off,
  output logic [BLK_SIZE/8-1:0]        wstrb
);

  localparam int NB   = BLK_SIZE / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [NB-1:0] B1 = NB'(1);
  localparam logic [NB-1:0] B2 = NB'(3);
  localparam logic [NB-1:0] B4 = NB'(15);

  logic [OFFW-1:0] off_h;
  logic [OFFW-1:0] off_w;

  assign off_h = {off[OFFW-1:1], 1'b0};
  assign off_w = {off[OFFW-1:2], 2'b00};

  always_comb begin
    wstrb = '0;
    if (rw) begin
      unique case (rw_size)
        ceres_param::NO_SIZE: wstrb = '1;
        ceres_param::BYTE:    wstrb = B1 << off;
        ceres_param::HALF:    wstrb = B2 << off_h;
        ceres_param::WORD:    wstrb = B4 << off_w;
        default:              wstrb = '0;
      endcase
    end
  end

endmodule

// File: rtl/l2_port_responder.sv
// L2-side endpoint of one lowX port: one request in flight,
// issued to flat backing memory, answered with a one-cycle pulse.
module l2_port_responder #(
  parameter int          BLK_SIZE = 128,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  ceres_param::lowX_req_t l1_req_i,
  output ceres_param::lowX_res_t l1_res_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [31:0]            mem_addr_o,
  output logic                   mem_we_o,
  output logic [BLK_SIZE-1:0]    mem_wdata_o,
  output logic [BLK_SIZE/8-1:0]  mem_wstrb_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [BLK_SIZE-1:0]    mem_rsp_data_i,
  output logic                   err_o
);

  localparam int NB   = BLK_SIZE / 8;
  localparam int OFFW = $clog2(NB);

  ceres_param::l2_resp_state_e state_q, state_d;
  ceres_param::rw_size_e       size_q;

  logic [31:0]                  addr_q;
  logic                         rw_q;
  logic [BLK_SIZE-1:0]          data_q;
  logic [ceres_param::ID_W-1:0] id_q;
  logic [BLK_SIZE-1:0]          blk_q, blk_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         cap;
  logic                         unused_req;

  // uncached only matters to the response path upstream
  assign unused_req = ^{l1_req_i.ready, l1_req_i.uncached};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ceres_param::IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= ceres_param::NO_SIZE;
      data_q  <= '0;
      id_q    <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (cap) begin
        addr_q <= l1_req_i.addr;
        rw_q   <= l1_req_i.rw;
        size_q <= l1_req_i.rw_size;
        data_q <= l1_req_i.data;
        id_q   <= l1_req_i.id;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap     = 1'b0;
    unique case (state_q)
      ceres_param::IDLE: begin
        if (l1_req_i.valid) begin
          cap     = 1'b1;
          state_d = ceres_param::ISSUE;
        end
      end
      ceres_param::ISSUE: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = ceres_param::WAIT;
        end
      end
      ceres_param::WAIT: begin
        // a response on the terminal count still wins
        if (mem_rsp_valid_i) begin
          blk_d   = rw_q ? '0 : mem_rsp_data_i;
          state_d = ceres_param::RESP;
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT - 1) begin
          err_d   = 1'b1;
          blk_d   = '0;
          state_d = ceres_param::RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ceres_param::RESP: state_d = ceres_param::IDLE;
      default:           state_d = ceres_param::IDLE;
    endcase
  end

  l2_wstrb_gen #(
    .BLK_SIZE(BLK_SIZE)
  ) u_wstrb (
    .rw     (rw_q),
    .rw_size(size_q),
    .off    (addr_q[OFFW-1:0]),
    .wstrb  (mem_wstrb_o)
  );

  assign mem_req_valid_o = (state_q == ceres_param::ISSUE);
  assign mem_addr_o      = {addr_q[31:OFFW], {OFFW{1'b0}}};
  assign mem_we_o        = rw_q;
  assign mem_wdata_o     = data_q;
  assign err_o           = err_q;

  always_comb begin
    l1_res_o       = '0;
    l1_res_o.valid = (state_q == ceres_param::RESP);
    l1_res_o.ready = (state_q == ceres_param::IDLE) && !rst_i;
    l1_res_o.blk   = blk_q;
    l1_res_o.id    = id_q;
  end

endmodule

// File: tb/tb_l2_port_responder.sv
// Randomized bench for l2_port_responder with TIMEOUT=8.
// Expectations come from an address/strobe/latency model.
module tb_l2_port_responder;
  import ceres_param::*;

  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  lowX_req_t     req;
  lowX_res_t     res;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [127:0]  mem_wdata;
  logic [15:0]   mem_wstrb;
  logic          mem_rsp_valid;
  logic [127:0]  mem_rsp_data;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_port_responder #(
    .BLK_SIZE(128),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .l1_req_i       (req),
    .l1_res_o       (res),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_wdata_o    (mem_wdata),
    .mem_wstrb_o    (mem_wstrb),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .err_o          (err)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] model_strb(logic w, rw_size_e sz,
                                             logic [31:0] a);
    logic [15:0] s;
    int len, base;
    s = '0;
    if (!w) return s;
    case (sz)
      NO_SIZE: len = 16;
      BYTE:    len = 1;
      HALF:    len = 2;
      default: len = 4;
    endcase
    base = (int'(a % 16) / len) * len;
    for (int b = 0; b < 16; b++)
      if (b >= base && b < base + len) s[b] = 1'b1;
    return s;
  endfunction

  function automatic int model_lat(int rsp_wait);
    if (rsp_wait >= 0 && rsp_wait < TMO) return rsp_wait + 1;
    return TMO;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; returns what the bench observed.
  task automatic do_txn(
    input  logic [31:0]  a,
    input  logic         w,
    input  rw_size_e     sz,
    input  logic [127:0] d,
    input  logic [3:0]   id,
    input  int           rdy_wait,
    input  int           rsp_wait,
    input  logic [127:0] rdata,
    output logic [31:0]  o_addr,
    output logic         o_we,
    output logic [15:0]  o_strb,
    output logic [127:0] o_wdata,
    output logic         o_stable,
    output logic         o_busy_ok,
    output int           o_lat,
    output logic [127:0] o_blk,
    output logic [3:0]   o_id,
    output logic         o_rdy_after
  );
    req.valid    = 1'b1;
    req.addr     = a;
    req.rw       = w;
    req.rw_size  = sz;
    req.data     = d;
    req.id       = id;
    req.uncached = 1'($urandom);
    tick();
    req.valid   = 1'b0;
    req.addr    = $urandom;
    req.rw      = 1'($urandom);
    req.rw_size = rw_size_e'($urandom_range(0, 3));
    req.data    = rnd128();
    req.id      = 4'($urandom);
    o_stable  = 1'b1;
    o_busy_ok = 1'b1;
    o_addr    = '0;
    o_we      = 1'b0;
    o_strb    = '0;
    o_wdata   = '0;
    for (int r = 0; r <= rdy_wait; r++) begin
      mem_req_ready = (r == rdy_wait);
      @(negedge clk);
      if (r == 0) begin
        o_addr  = mem_addr;
        o_we    = mem_we;
        o_strb  = mem_wstrb;
        o_wdata = mem_wdata;
      end else if (o_addr !== mem_addr || o_we !== mem_we ||
                   o_strb !== mem_wstrb || o_wdata !== mem_wdata) begin
        o_stable = 1'b0;
      end
      if (res.ready !== 1'b0 || mem_req_valid !== 1'b1) o_busy_ok = 1'b0;
      tick();
    end
    mem_req_ready = 1'b0;
    o_lat = -1;
    o_blk = '0;
    o_id  = '0;
    for (int j = 0; j < 64; j++) begin
      if (j == rsp_wait) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata;
      end
      @(negedge clk);
      if (res.ready !== 1'b0 || mem_req_valid !== 1'b0) o_busy_ok = 1'b0;
      if (res.valid === 1'b1) begin
        o_lat = j;
        o_blk = res.blk;
        o_id  = res.id;
      end
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = rnd128();
      if (o_lat >= 0) break;
    end
    @(negedge clk);
    o_rdy_after = res.ready && !res.valid;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({res.valid, res.ready, mem_req_valid, mem_we, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {res.valid, res.ready, mem_req_valid, mem_we, err});
    end
    total++;
    if (res.blk !== '0 || res.id !== '0 || mem_wstrb !== '0) begin
      bad++;
      $display("FAIL reset_data blk=%0h id=%0h strb=%0h exp=0",
               res.blk, res.id, mem_wstrb);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (res.ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", res.ready);
    end
    tick();
  endtask

  task automatic test_plan_read();
    logic [31:0] oa;
    logic ow, st, bz, ra;
    logic [15:0] os;
    logic [127:0] od, ob, rd;
    logic [3:0] oi;
    int lat;
    rd = {16{8'hA5}};
    do_txn(32'h8000_0014, 1'b0, WORD, rnd128(), 4'd3, 0, 2, rd,
           oa, ow, os, od, st, bz, lat, ob, oi, ra);
    total++;
    if (oa !== 32'h8000_0010) begin
      bad++; $display("FAIL plan_addr got=%h exp=80000010", oa);
    end
    total++;
    if (ow !== 1'b0 || os !== 16'h0) begin
      bad++; $display("FAIL plan_rd_strb we=%b strb=%h exp=0/0000", ow, os);
    end
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL plan_latency got=%0d exp=3", lat);
    end
    total++;
    if (oi !== 4'd3 || ob !== rd) begin
      bad++; $display("FAIL plan_resp id=%0d blk=%h exp=3/%h", oi, ob, rd);
    end
    total++;
    if (ra !== 1'b1 || bz !== 1'b1) begin
      bad++; $display("FAIL plan_ready after=%b busy_ok=%b exp=1/1", ra, bz);
    end
  endtask

  task automatic test_strobes();
    rw_size_e    szs  [4] = '{BYTE, HALF, WORD, NO_SIZE};
    logic [31:0] adrs [4] = '{32'h1000_0007, 32'h1000_0025,
                              32'h1000_0046, 32'h1000_0063};
    logic [15:0] lits [4] = '{16'h0080, 16'h0030, 16'h00F0, 16'hFFFF};
    logic [31:0] oa;
    logic ow, st, bz, ra;
    logic [15:0] os;
    logic [127:0] od, ob, wd;
    logic [3:0] oi;
    int lat;
    for (int i = 0; i < 4; i++) begin
      wd = rnd128();
      do_txn(adrs[i], 1'b1, szs[i], wd, 4'(i), 0, 1, rnd128(),
             oa, ow, os, od, st, bz, lat, ob, oi, ra);
      total++;
      if (os !== lits[i] || os !== model_strb(1'b1, szs[i], adrs[i])) begin
        bad++;
        $display("FAIL strb_%0d got=%h exp=%h", i, os, lits[i]);
      end
      total++;
      if (ow !== 1'b1 || od !== wd || ob !== '0) begin
        bad++;
        $display("FAIL wr_%0d we=%b wdata=%h blk=%h exp=1/%h/0",
                 i, ow, od, ob, wd);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] oa;
    logic ow, st, bz, ra;
    logic [15:0] os;
    logic [127:0] od, ob;
    logic [3:0] oi;
    int lat;
    do_txn(32'h2000_0035, 1'b1, HALF, rnd128(), 4'd9, 7, 0, rnd128(),
           oa, ow, os, od, st, bz, lat, ob, oi, ra);
    total++;
    if (st !== 1'b1 || os !== 16'h0030 || oa !== 32'h2000_0030) begin
      bad++;
      $display("FAIL stall_stable st=%b strb=%h addr=%h exp=1/0030/20000030",
               st, os, oa);
    end
    total++;
    if (bz !== 1'b1 || lat !== 1 || oi !== 4'd9) begin
      bad++;
      $display("FAIL stall_busy ok=%b lat=%0d id=%0d exp=1/1/9", bz, lat, oi);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, oa;
    logic w, ow, st, bz, ra;
    rw_size_e sz;
    logic [15:0] os;
    logic [127:0] d, rd, od, ob, eb;
    logic [3:0] id, oi;
    int rw_w, rs_w, lat;
    for (int n = 0; n < 24; n++) begin
      a    = $urandom;
      w    = 1'($urandom);
      sz   = rw_size_e'($urandom_range(0, 3));
      d    = rnd128();
      rd   = rnd128();
      id   = 4'($urandom);
      rw_w = $urandom_range(0, 3);
      rs_w = $urandom_range(0, 6);
      eb   = w ? '0 : rd;
      do_txn(a, w, sz, d, id, rw_w, rs_w, rd,
             oa, ow, os, od, st, bz, lat, ob, oi, ra);
      total++;
      if (oa !== (a & ~32'hF) || ow !== w || od !== d) begin
        bad++;
        $display("FAIL rnd_req_%0d addr=%h we=%b exp=%h/%b",
                 n, oa, ow, a & ~32'hF, w);
      end
      total++;
      if (os !== model_strb(w, sz, a)) begin
        bad++;
        $display("FAIL rnd_strb_%0d got=%h exp=%h",
                 n, os, model_strb(w, sz, a));
      end
      total++;
      if (lat !== model_lat(rs_w) || ob !== eb || oi !== id) begin
        bad++;
        $display("FAIL rnd_resp_%0d lat=%0d id=%0d exp=%0d/%0d",
                 n, lat, oi, model_lat(rs_w), id);
      end
      total++;
      if (st !== 1'b1 || bz !== 1'b1 || ra !== 1'b1) begin
        bad++;
        $display("FAIL rnd_hs_%0d st=%b busy=%b rdy=%b exp=111",
                 n, st, bz, ra);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] oa;
    logic ow, st, bz, ra;
    logic [15:0] os;
    logic [127:0] od, ob, rd;
    logic [3:0] oi;
    int lat;
    rd = rnd128();
    do_txn(32'h3000_0000, 1'b0, NO_SIZE, rnd128(), 4'd5, 0, TMO - 1, rd,
           oa, ow, os, od, st, bz, lat, ob, oi, ra);
    total++;
    if (lat !== TMO || ob !== rd || err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_edge lat=%0d err=%b exp=%0d/0", lat, err, TMO);
    end
    do_txn(32'h3000_0040, 1'b0, NO_SIZE, rnd128(), 4'd6, 1, -1, rnd128(),
           oa, ow, os, od, st, bz, lat, ob, oi, ra);
    total++;
    if (lat !== TMO || ob !== '0 || oi !== 4'd6 || err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_fire lat=%0d blk=%h id=%0d err=%b exp=%0d/0/6/1",
               lat, ob, oi, err, TMO);
    end
    rd = rnd128();
    do_txn(32'h3000_0080, 1'b0, BYTE, rnd128(), 4'd7, 0, 1, rd,
           oa, ow, os, od, st, bz, lat, ob, oi, ra);
    total++;
    if (lat !== 2 || ob !== rd || err !== 1'b1 || ra !== 1'b1) begin
      bad++;
      $display("FAIL tmo_after lat=%0d err=%b rdy=%b exp=2/1/1",
               lat, err, ra);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    req.valid   = 1'b1;
    req.addr    = 32'h4000_0010;
    req.rw      = 1'b0;
    req.rw_size = WORD;
    req.id      = 4'd12;
    tick();
    req.valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (res.ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ready got=%b exp=0", res.ready);
    end
    tick();
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rnd128();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res.valid !== 1'b0 || res.ready !== 1'b1 ||
          mem_req_valid !== 1'b0) seen++;
      tick();
      mem_rsp_valid = 1'b0;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL mid_rst_idle bad_cycles=%0d exp=0", seen);
    end
    total++;
    if (err !== 1'b0 || res.blk !== '0) begin
      bad++; $display("FAIL mid_rst_clear err=%b exp=0", err);
    end
  endtask

  initial begin
    test_reset();
    test_plan_read();
    test_strobes();
    test_stall();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
